// File: rtl/approx_error_monitor_pkg.sv
// Shared types and sizing helpers for the approximate-adder error monitor.
package approx_mon_pkg;

  // Monitor control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default adder operand width (M+N) and batch counter width.
  localparam int DEF_W     = 8;
  localparam int DEF_CNT_W = 16;

  // Accumulator width: one maximal error (W+1 bits) added up to 2^cnt_w-1 times
  // cannot exceed w+1+cnt_w bits, so the running sum never wraps.
  function automatic int acc_width(input int w, input int cnt_w);
    return w + 1 + cnt_w;
  endfunction

endpackage

// File: rtl/approx_error_monitor_abs_err_stage.sv
// Registered |a - b| stage with nonzero flag and a one-cycle valid pulse.
module abs_err_stage #(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [W:0] a,
  input  logic [W:0] b,
  output logic       out_valid,
  output logic [W:0] d,
  output logic       nz
);

  localparam logic [W:0] ONE = (W + 1)'(1);

  logic [W+1:0] diff;
  logic [W:0]   abs_c;

  // Subtract at W+2 bits so the sign is explicit, then fold to a magnitude.
  always_comb begin
    diff  = {1'b0, a} - {1'b0, b};
    abs_c = diff[W+1] ? (~diff[W:0] + ONE) : diff[W:0];
  end

  // Valid bit follows the accept strobe and is the only stage state that resets.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples
    // pre-edge values regardless of statement order.
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

  // Capture the magnitude and its nonzero flag on every accepted sample.
  always_ff @(posedge clk) begin
    // NOTE: data registers carry no reset; they are consumed only when out_valid
    // is high, which does reset, so stale contents are never observed.
    if (in_valid) begin
      d  <= abs_c;
      nz <= |abs_c;
    end
  end

endmodule

// File: rtl/approx_error_monitor.sv
// Batch error-statistics collector for the hybrid approximate adder: compares
// each approximate sum with the exact sum and reports count/sum/max of |error|.
module approx_error_monitor
  import approx_mon_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int ACC_W = acc_width(W, CNT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W:0]       approx_sum,
  input  logic [W:0]       exact_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       max_abs_err
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q;
  logic             start_ok;
  logic             accept;

  logic             s1_valid;
  logic [W:0]       s1_d;
  logic             s1_nz;

  assign accept = in_valid & in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and Moore outputs; start is only honoured from IDLE or DONE.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          start_ok = 1'b1;
          state_d  = (num_samples != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && remaining_q == CNT_ONE) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Samples still expected in this batch.
  always_ff @(posedge clk) begin
    if (rst)           remaining_q <= '0;
    else if (start_ok) remaining_q <= num_samples;
    else if (accept)   remaining_q <= remaining_q - CNT_ONE;
  end

  // Stage 1: registered absolute error of each accepted sample.
  abs_err_stage #(
    .W (W)
  ) u_abs_err_stage (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept),
    .a         (approx_sum),
    .b         (exact_sum),
    .out_valid (s1_valid),
    .d         (s1_d),
    .nz        (s1_nz)
  );

  // Stage 2: fold each stage-1 result into the batch statistics; a new batch
  // clears them, and no stage-1 result is ever pending when start is honoured.
  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      err_count   <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else if (s1_valid) begin
      err_count   <= err_count + CNT_W'(s1_nz);
      sum_abs_err <= sum_abs_err + ACC_W'(s1_d);
      if (s1_d > max_abs_err) max_abs_err <= s1_d;
    end
  end

endmodule

// File: tb/tb_approx_error_monitor.sv
// Directed self-checking bench for approx_error_monitor (W=8, CNT_W=16).
module tb_approx_error_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int ACC_W = W + 1 + CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_samples;
  logic             in_valid;
  logic             in_ready;
  logic [W:0]       approx_sum;
  logic [W:0]       exact_sum;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] err_count;
  logic [ACC_W-1:0] sum_abs_err;
  logic [W:0]       max_abs_err;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  approx_error_monitor #(
    .W     (W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .approx_sum  (approx_sum),
    .exact_sum   (exact_sum),
    .busy        (busy),
    .done        (done),
    .err_count   (err_count),
    .sum_abs_err (sum_abs_err),
    .max_abs_err (max_abs_err)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_stats(input string tag, input int e, input int s, input int m);
    check({tag, "_err_count"},   32'(err_count),   32'(e));
    check({tag, "_sum_abs_err"}, 32'(sum_abs_err), 32'(s));
    check({tag, "_max_abs_err"}, 32'(max_abs_err), 32'(m));
  endtask

  // Present one sample; in_ready is registered, so it predicts the coming edge.
  task automatic send(input int a, input int e);
    in_valid   = 1'b1;
    approx_sum = (W + 1)'(a);
    exact_sum  = (W + 1)'(e);
    check("send_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_start(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = '0;
    in_valid = 1'b0; approx_sum = '0; exact_sum = '0;
    tick(); tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done",     32'(done),     32'd0);
    check_stats("rst", 0, 0, 0);
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Batch 1: error-free samples.
    pulse_start(4);
    check("t1_run_busy",  32'(busy),     32'd1);
    check("t1_run_ready", 32'(in_ready), 32'd1);
    send(7, 7); send(300, 300); send(0, 0); send(511, 511);
    check("t1_drain_done",  32'(done),     32'd0);
    check("t1_drain_busy",  32'(busy),     32'd1);
    check("t1_drain_ready", 32'(in_ready), 32'd0);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check_stats("t1", 0, 0, 0);

    // Batch 2: back-to-back samples with errors 2,5,0,1.
    pulse_start(4);
    send(10, 12); send(255, 250); send(0, 0); send(100, 101);
    check("t2_drain_done", 32'(done), 32'd0);
    tick();
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check_stats("t2", 3, 8, 5);

    // Batch 3: same samples with gaps, then a stalled sample after the last.
    pulse_start(4);
    check_stats("t3_clear", 0, 0, 0);
    send(10, 12); tick();
    send(255, 250); tick();
    send(0, 0); tick();
    send(100, 101);
    in_valid = 1'b1; approx_sum = 9'd3; exact_sum = 9'd9;
    check("t3_drain_ready", 32'(in_ready), 32'd0);
    tick();
    check("t3_done",       32'(done),     32'd1);
    check("t3_done_ready", 32'(in_ready), 32'd0);
    tick();
    check_stats("t3", 3, 8, 5);
    in_valid = 1'b0;

    // Batch 4: extremes.
    pulse_start(2);
    send(0, 511); send(511, 0);
    tick();
    check("t4_done", 32'(done), 32'd1);
    check_stats("t4", 2, 1022, 511);

    // Empty batch from DONE clears the previous statistics.
    pulse_start(0);
    check("t5a_done", 32'(done), 32'd1);
    check("t5a_busy", 32'(busy), 32'd0);
    check_stats("t5a", 0, 0, 0);

    // Empty batch from IDLE.
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5b_idle_done", 32'(done), 32'd0);
    pulse_start(0);
    check("t5b_done", 32'(done), 32'd1);
    check_stats("t5b", 0, 0, 0);

    // start during RUN must not reload the remaining count.
    pulse_start(3);
    send(1, 2);
    pulse_start(5);
    check("t5c_run_busy",  32'(busy),     32'd1);
    check("t5c_run_ready", 32'(in_ready), 32'd1);
    send(4, 4); send(0, 3);
    check("t5c_drain_done", 32'(done), 32'd0);
    check("t5c_drain_busy", 32'(busy), 32'd1);
    tick();
    check("t5c_done", 32'(done), 32'd1);
    check_stats("t5c", 2, 4, 3);

    // Reset mid-batch overrides start and in_valid and discards partial results.
    pulse_start(4);
    send(10, 12); send(255, 250);
    rst = 1'b1; start = 1'b1; num_samples = 16'd4;
    in_valid = 1'b1; approx_sum = 9'd5; exact_sum = 9'd0;
    tick();
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_busy",  32'(busy),     32'd0);
    check("t6_rst_done",  32'(done),     32'd0);
    check_stats("t6_rst", 0, 0, 0);
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    tick();
    check("t6_idle_busy", 32'(busy), 32'd0);
    check("t6_idle_done", 32'(done), 32'd0);
    check_stats("t6_idle", 0, 0, 0);

    // Restart from DONE: statistics reflect only the new batch.
    pulse_start(0);
    pulse_start(1);
    send(7, 3);
    tick();
    check("t6b_done", 32'(done), 32'd1);
    check_stats("t6b", 1, 4, 4);
    pulse_start(2);
    check_stats("t6c_clear", 0, 0, 0);
    send(1, 0); send(0, 0);
    tick();
    check("t6c_done", 32'(done), 32'd1);
    check_stats("t6c", 1, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
